// File: rtl/neuron_layer_sequencer.sv
// Steps one shared signed 8x8 MAC across M neurons of N inputs each and drives
// the input/weight memory addresses. Each ReLU result goes out on a valid/ready port.
module neuron_layer_sequencer #(
    parameter int N = 9,
    parameter int M = 4,
    localparam int ACC_W = 16 + $clog2(N),
    localparam int IDX_W = (M > 1) ? $clog2(M) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [31:0]      x_adr,
    output logic [31:0]      w_adr,
    input  logic [7:0]       x,
    input  logic [7:0]       w,
    output logic [ACC_W-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int I_W = $clog2(N);
    localparam logic [I_W-1:0]   I_LAST = I_W'(N - 1);
    localparam logic [IDX_W-1:0] J_LAST = IDX_W'(M - 1);

    typedef enum logic [1:0] {IDLE, ACC, EMIT, DONE} state_t;

    state_t                   state_reg, state_next;
    logic [I_W-1:0]           i_reg;
    logic [IDX_W-1:0]         j_reg;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic [ACC_W-1:0]         out_data_reg;
    logic signed [15:0]       prod;
    logic                     last_input;

    assign prod       = $signed(x) * $signed(w);
    assign acc_next   = acc_reg + {{(ACC_W-16){prod[15]}}, prod};
    assign last_input = (i_reg == I_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = ACC;
            ACC:  if (last_input) state_next = EMIT;
            EMIT: if (out_ready) state_next = (j_reg == J_LAST) ? DONE : ACC;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != IDLE);
        done      = (state_reg == DONE);
        out_valid = (state_reg == EMIT);
        x_adr     = '0;
        w_adr     = '0;
        out_data  = '0;
        out_idx   = '0;
        if (state_reg == ACC) begin
            x_adr = 32'(i_reg);
            w_adr = 32'(j_reg) * 32'(N) + 32'(i_reg);
        end
        if (state_reg == EMIT) begin
            out_data = out_data_reg;
            out_idx  = j_reg;
        end
    end

    // Datapath only moves in ACC and on an accepted EMIT, so a stalled EMIT freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_reg        <= '0;
            j_reg        <= '0;
            acc_reg      <= '0;
            out_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        i_reg   <= '0;
                        j_reg   <= '0;
                        acc_reg <= '0;
                    end
                end
                ACC: begin
                    acc_reg <= acc_next;
                    i_reg   <= last_input ? '0 : i_reg + I_W'(1);
                    if (last_input) begin
                        out_data_reg <= acc_next[ACC_W-1] ? '0 : acc_next;
                    end
                end
                EMIT: begin
                    if (out_ready && (j_reg != J_LAST)) begin
                        j_reg   <= j_reg + IDX_W'(1);
                        i_reg   <= '0;
                        acc_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Scoreboard bench: a small layer (N=3, M=2) for sequencing/backpressure/reset
// and a wide layer (N=9, M=1) for accumulator range.
module tb_neuron_layer_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int     idx;
        longint data;
        int     cyc;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];
    int   a_dq[$];
    int   b_dq[$];

    // small layer
    logic        a_start, a_busy, a_done, a_out_valid, a_out_ready;
    logic [31:0] a_x_adr, a_w_adr;
    logic [7:0]  a_x, a_w;
    logic [17:0] a_out_data;
    logic [0:0]  a_out_idx;
    logic signed [7:0] a_xm [3];
    logic signed [7:0] a_wm [6];

    // wide layer
    logic        b_start, b_busy, b_done, b_out_valid, b_out_ready;
    logic [31:0] b_x_adr, b_w_adr;
    logic [7:0]  b_x, b_w, b_xv, b_wv;
    logic [19:0] b_out_data;
    logic [0:0]  b_out_idx;

    always_comb a_x = (a_x_adr < 32'd3) ? a_xm[a_x_adr[1:0]] : 8'd0;
    always_comb a_w = (a_w_adr < 32'd6) ? a_wm[a_w_adr[2:0]] : 8'd0;
    always_comb b_x = b_xv;
    always_comb b_w = b_wv;

    neuron_layer_sequencer #(.N(3), .M(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .x_adr(a_x_adr), .w_adr(a_w_adr), .x(a_x), .w(a_w),
        .out_data(a_out_data), .out_idx(a_out_idx),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    neuron_layer_sequencer #(.N(9), .M(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .x_adr(b_x_adr), .w_adr(b_w_adr), .x(b_x), .w(b_w),
        .out_data(b_out_data), .out_idx(b_out_idx),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle count %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   dc;
        if (a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
                check("a_spurious_out", 1, 0);
            end else begin
                e = a_q.pop_front();
                check("a_out_data", a_out_data, e.data);
                check("a_out_idx", a_out_idx, e.idx);
                check("a_out_cycle", cyc, e.cyc);
            end
        end
        if (a_done) begin
            if (a_dq.size() == 0) begin
                check("a_spurious_done", 1, 0);
            end else begin
                dc = a_dq.pop_front();
                check("a_done_cycle", cyc, dc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   dc;
        if (b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
                check("b_spurious_out", 1, 0);
            end else begin
                e = b_q.pop_front();
                check("b_out_data", b_out_data, e.data);
                check("b_out_idx", b_out_idx, e.idx);
                check("b_out_cycle", cyc, e.cyc);
            end
        end
        if (b_done) begin
            if (b_dq.size() == 0) begin
                check("b_spurious_done", 1, 0);
            end else begin
                dc = b_dq.pop_front();
                check("b_done_cycle", cyc, dc);
            end
        end
    end

    task automatic load_a(input int x0, input int x1, input int x2,
                          input int w0, input int w1, input int w2,
                          input int w3, input int w4, input int w5);
        a_xm[0] = 8'(x0); a_xm[1] = 8'(x1); a_xm[2] = 8'(x2);
        a_wm[0] = 8'(w0); a_wm[1] = 8'(w1); a_wm[2] = 8'(w2);
        a_wm[3] = 8'(w3); a_wm[4] = 8'(w4); a_wm[5] = 8'(w5);
    endtask

    // Runs one full layer on the small DUT; stall = cycles out_ready is low in neuron 0's EMIT.
    task automatic run_a(input int stall, input bit poke, input longint e0, input longint e1);
        exp_t e;
        int   c0;
        int   i_e;
        int   j_e;
        bit   in_acc;
        c0 = cyc;
        e.idx = 0; e.data = e0; e.cyc = c0 + 4 + stall; a_q.push_back(e);
        e.idx = 1; e.data = e1; e.cyc = c0 + 8 + stall; a_q.push_back(e);
        a_dq.push_back(c0 + 9 + stall);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 1; k <= 11 + stall; k++) begin
            in_acc = 1'b0; i_e = 0; j_e = 0;
            if (k <= 3) begin
                in_acc = 1'b1; i_e = k - 1;
            end else if (k >= 5 + stall && k <= 7 + stall) begin
                in_acc = 1'b1; i_e = k - 5 - stall; j_e = 1;
            end
            check("a_x_adr", a_x_adr, in_acc ? i_e : 0);
            check("a_w_adr", a_w_adr, in_acc ? j_e * 3 + i_e : 0);
            check("a_busy", a_busy, (k <= 9 + stall) ? 1 : 0);
            if (k >= 4 && k <= 4 + stall) begin
                check("a_hold_valid", a_out_valid, 1);
                check("a_hold_data", a_out_data, e0);
                check("a_hold_idx", a_out_idx, 0);
            end
            a_start = poke && (k == 2 || k == 4);
            if (stall > 0) a_out_ready = !(k >= 3 && k < 4 + stall);
            tick();
        end
        a_start = 1'b0;
        a_out_ready = 1'b1;
    endtask

    task automatic run_b(input logic [7:0] xv, input logic [7:0] wv, input longint exp_data);
        exp_t e;
        int   c0;
        b_xv = xv;
        b_wv = wv;
        c0 = cyc;
        e.idx = 0; e.data = exp_data; e.cyc = c0 + 10; b_q.push_back(e);
        b_dq.push_back(c0 + 11);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            check("b_x_adr", b_x_adr, (k <= 9) ? k - 1 : 0);
            check("b_w_adr", b_w_adr, (k <= 9) ? k - 1 : 0);
            tick();
        end
    endtask

    task automatic check_a_quiet(input string tag);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_done"}, a_done, 0);
        check({tag, "_valid"}, a_out_valid, 0);
        check({tag, "_x_adr"}, a_x_adr, 0);
        check({tag, "_w_adr"}, a_w_adr, 0);
        check({tag, "_data"}, a_out_data, 0);
        check({tag, "_idx"}, a_out_idx, 0);
    endtask

    initial begin
        exp_t e;
        int   c0;
        a_start = 1'b0; a_out_ready = 1'b1;
        b_start = 1'b0; b_out_ready = 1'b1;
        b_xv = 8'd0; b_wv = 8'd0;
        load_a(1, 2, 3, 1, 1, 1, -1, -1, -1);

        // reset state, then idle after release with no start
        repeat (3) tick();
        check_a_quiet("rst");
        check("rst_b_busy", b_busy, 0);
        rst = 1'b1;
        repeat (3) tick();
        check_a_quiet("idle");

        // basic layer with address sweep: 6 then ReLU(-6)=0
        run_a(0, 1'b0, 6, 0);

        // backpressure on neuron 0
        load_a(5, -3, 7, 2, -4, 1, 3, 3, 3);
        run_a(5, 1'b0, 29, 27);

        // start poked during ACC and EMIT must be ignored
        load_a(-7, 4, 100, 1, 2, 3, -2, -1, 1);
        run_a(0, 1'b1, 301, 110);

        // reset in the middle of neuron 1 accumulation
        load_a(1, 2, 3, 1, 1, 1, -1, -1, -1);
        c0 = cyc;
        e.idx = 0; e.data = 6; e.cyc = c0 + 4; a_q.push_back(e);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (5) tick();
        check("mid_acc_x_adr", a_x_adr, 1);
        check("mid_acc_w_adr", a_w_adr, 4);
        rst = 1'b0;
        #1;
        check_a_quiet("async_rst");
        check("rst_queue_drained", a_q.size(), 0);
        tick();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check_a_quiet("post_rst");
        run_a(0, 1'b0, 6, 0);

        // accumulator range on the wide layer
        run_b(8'h80, 8'h80, 147456);
        run_b(8'h80, 8'h7f, 0);

        repeat (3) tick();
        check("a_q_empty", a_q.size(), 0);
        check("a_dq_empty", a_dq.size(), 0);
        check("b_q_empty", b_q.size(), 0);
        check("b_dq_empty", b_dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
